// File: rtl/uart_mmio_pkg.sv
// uart_mmio_pkg -- shared definitions for the UART MMIO controller.
//   * CPU-visible register addresses (full 32-bit byte addresses)
//   * STATUS register bit positions
//   * TX FSM state encoding
package uart_mmio_pkg;

  localparam logic [31:0] RX_DATA_ADDR = 32'h1001_002C;
  localparam logic [31:0] TX_DATA_ADDR = 32'h1001_0030;
  localparam logic [31:0] STATUS_ADDR  = 32'h1001_0034;

  localparam int STAT_TX_FULL    = 0;
  localparam int STAT_TX_EMPTY   = 1;
  localparam int STAT_RX_FULL    = 2;
  localparam int STAT_RX_OVERRUN = 3;
  localparam int STAT_TX_DROP    = 4;

  typedef enum logic [1:0] {
    TX_IDLE      = 2'd0,
    TX_LAUNCH    = 2'd1,
    TX_WAIT_BUSY = 2'd2,
    TX_WAIT_DONE = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo -- TX byte buffer for uart_mmio_ctrl.
// Build option: UART_MMIO_TX_FIFO_EN
//   defined   -> DEPTH-entry circular FIFO (DEPTH power of 2, >= 2)
//   undefined -> single holding register (DEPTH ignored)
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   push, din    enqueue request and byte; ignored when full unless pop
//                is accepted in the same cycle
//   pop          dequeue request; ignored when empty
//   full, empty  occupancy flags
//   head         byte at the front of the buffer
module uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic       full,
  output logic       empty,
  output logic [7:0] head
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: DEPTH must be a power of 2 and >= 2");
  end

  logic do_push;
  logic do_pop;

`ifdef UART_MMIO_TX_FIFO_EN
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer width is exactly log2(DEPTH), so increments wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
`else
  logic [7:0] hold;
  logic       occupied;

  assign full    = occupied;
  assign empty   = !occupied;
  assign head    = hold;
  assign do_pop  = pop && occupied;
  assign do_push = push && (!occupied || do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold     <= '0;
      occupied <= 1'b0;
    end else begin
      if (do_push) hold <= din;
      occupied <= do_push || (occupied && !do_pop);
    end
  end
`endif

endmodule

// File: rtl/uart_mmio_ctrl.sv
// uart_mmio_ctrl -- memory-mapped CPU interface to a UART TX/RX pair.
// Build option: UART_MMIO_TX_FIFO_EN selects a TX_DEPTH-entry TX FIFO;
// without it the TX buffer is a single holding register.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   wr_en, rd_en         CPU store / load strobes
//   address, wr_data     CPU byte address and store data
//   rd_data              combinational load data (independent of rd_en)
//   tx_start, tx_data    one-cycle launch pulse and byte to the transmitter
//   tx_busy              transmitter busy
//   rx_valid, rx_data    one-cycle received-byte pulse and byte
// Transmitter handshake: a byte is launched only while tx_busy is low;
// tx_start is high for the single LAUNCH cycle, then the FSM waits for
// tx_busy to rise and fall again before the next launch. tx_data holds
// the most recently launched byte until the next launch.
module uart_mmio_ctrl
  import uart_mmio_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int TX_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           wr_data,
  output logic [31:0]           rd_data,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  input  logic                  tx_busy,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data
);

  tx_state_t  state;
  tx_state_t  state_next;
  logic       launch_go;

  logic       sel_rx;
  logic       sel_tx;
  logic       sel_status;

  logic       fifo_push;
  logic       fifo_pop;
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_head;

  logic [7:0] rx_byte;
  logic       rx_full;
  logic       rx_overrun;
  logic       tx_drop;
  logic       tx_empty;
  logic       rx_clear;

  logic       unused_wr_bits;
  assign unused_wr_bits = ^wr_data[31:8];

  assign sel_rx     = (address == ADDR_WIDTH'(RX_DATA_ADDR));
  assign sel_tx     = (address == ADDR_WIDTH'(TX_DATA_ADDR));
  assign sel_status = (address == ADDR_WIDTH'(STATUS_ADDR));

  assign fifo_push = wr_en && sel_tx;
  assign fifo_pop  = (state == TX_LAUNCH);
  assign tx_empty  = fifo_empty && (state == TX_IDLE);
  assign rx_clear  = rd_en && sel_rx;

  uart_tx_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (wr_data[7:0]),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  // ---------------- TX FSM ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) state <= TX_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    tx_start   = 1'b0;
    launch_go  = 1'b0;
    case (state)
      TX_IDLE: begin
        if (!fifo_empty && !tx_busy) begin
          state_next = TX_LAUNCH;
          launch_go  = 1'b1;
        end
      end
      TX_LAUNCH: begin
        tx_start   = 1'b1;
        state_next = TX_WAIT_BUSY;
      end
      TX_WAIT_BUSY: if (tx_busy)  state_next = TX_WAIT_DONE;
      TX_WAIT_DONE: if (!tx_busy) state_next = TX_IDLE;
      default:      state_next = TX_IDLE;
    endcase
  end

  // Captured on entry to LAUNCH; the head cannot change while IDLE because
  // only LAUNCH pops, so tx_data equals the head byte during LAUNCH.
  always_ff @(posedge clk) begin
    if (!rst_n)         tx_data <= '0;
    else if (launch_go) tx_data <= fifo_head;
  end

  // ---------------- RX capture and sticky flags ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_byte    <= '0;
      rx_full    <= 1'b0;
      rx_overrun <= 1'b0;
      tx_drop    <= 1'b0;
    end else begin
      // A new byte wins over a clearing read in the same cycle.
      if (rx_valid) begin
        rx_byte <= rx_data;
        rx_full <= 1'b1;
      end else if (rx_clear) begin
        rx_full <= 1'b0;
      end

      // Sticky flags: set wins over write-1-to-clear.
      if (rx_valid && rx_full && !rx_clear)
        rx_overrun <= 1'b1;
      else if (wr_en && sel_status && wr_data[STAT_RX_OVERRUN])
        rx_overrun <= 1'b0;

      if (fifo_push && fifo_full && !fifo_pop)
        tx_drop <= 1'b1;
      else if (wr_en && sel_status && wr_data[STAT_TX_DROP])
        tx_drop <= 1'b0;
    end
  end

  // ---------------- Read mux ----------------
  always_comb begin
    rd_data = '0;
    if (sel_rx) begin
      rd_data[7:0] = rx_byte;
    end else if (sel_status) begin
      rd_data[STAT_TX_FULL]    = fifo_full;
      rd_data[STAT_TX_EMPTY]   = tx_empty;
      rd_data[STAT_RX_FULL]    = rx_full;
      rd_data[STAT_RX_OVERRUN] = rx_overrun;
      rd_data[STAT_TX_DROP]    = tx_drop;
    end
  end

endmodule
